// File: rtl/lynx_bank_ctl.sv
// lynx_bank_ctl: Lynx memory/IO bank controller: port 7F/80 latches, ROM/RAM/VRAM decode, video wait-state FSM.
//   clock, reset (async, active-low), ce (CPU clock enable)
//   mreq_n/iorq_n/wr_n/a/d : CPU bus;  de, cas : CRTC display enable and cursor/cas
//   bank7f, ctl80 (port 80 bits [5:1]), altg        : latched bank/control registers
//   ram_we_n, vram_we_n[PLANES], vram_a, rom_a      : memory strobes and addresses
//   rd_sel, rd_plane                                : read-source select for the top-level data mux
//   blank_mask[PLANES], wait_n                      : blink mask and CPU WAIT
// Optional: define LYNX_BANK_WAIT_EN to build the video-contention wait FSM; otherwise video access is zero-latency.
module lynx_bank_ctl #(
  parameter int PLANES = 3,
  parameter int ROM_AW = 15,
  parameter int VWAIT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              wr_n,
  input  logic [15:0]       a,
  input  logic [7:0]        d,
  input  logic              de,
  input  logic              cas,
  output logic [7:0]        bank7f,
  output logic [5:1]        ctl80,
  output logic              altg,
  output logic              ram_we_n,
  output logic [PLANES-1:0] vram_we_n,
  output logic [13:0]       vram_a,
  output logic [ROM_AW-1:0] rom_a,
  output logic [2:0]        rd_sel,
  output logic [2:0]        rd_plane,
  output logic [PLANES-1:0] blank_mask,
  output logic              wait_n
);
  localparam logic [15:0] ROM_TOP = (ROM_AW == 14) ? 16'h4000 : 16'h6000;
  logic [7:0] bank7f_q, bank7f_d;
  logic [5:1] ctl80_q, ctl80_d;
  logic       cas_q, cas_d, tog_q, tog_d;
  logic       io_wr, vid_wr, grant, vhit;
  logic [2:0] vplane;
  always_comb begin
    io_wr    = ce && !iorq_n && !wr_n;
    bank7f_d = (io_wr && a[6:0] == 7'h7f) ? d : bank7f_q;
    ctl80_d  = (io_wr && a[7] && !a[6] && !a[2] && !a[1]) ? d[5:1] : ctl80_q;
    cas_d    = ce ? cas : cas_q;
    tog_d    = tog_q ^ (ce && cas_q && !cas);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bank7f_q <= 8'h00;
      ctl80_q  <= 5'b00110;
      cas_q    <= 1'b0;
      tog_q    <= 1'b0;
    end else begin
      bank7f_q <= bank7f_d;
      ctl80_q  <= ctl80_d;
      cas_q    <= cas_d;
      tog_q    <= tog_d;
    end
  // Lowest readable plane: planes 0/1 have read-disable bits in ctl80, higher planes are always readable.
  always_comb begin
    vhit   = 1'b0;
    vplane = 3'd0;
    for (int k = PLANES - 1; k >= 0; k--)
      if (k >= 2 || (k == 0 && !ctl80_q[2]) || (k == 1 && !ctl80_q[3])) begin
        vhit   = 1'b1;
        vplane = 3'(k);
      end
  end
  always_comb begin
    rd_sel   = 3'd0;
    rd_plane = 3'd0;
    if (!mreq_n && !bank7f_q[4] && a < ROM_TOP) rd_sel = 3'd1;
    else if (!mreq_n && ROM_AW == 14 && a >= 16'h4000 && a < 16'h6000) rd_sel = 3'd0;
    else if (!mreq_n && !bank7f_q[5]) rd_sel = 3'd2;
    else if (!mreq_n && bank7f_q[6] && vhit) begin
      rd_sel   = 3'd3;
      rd_plane = vplane;
    end
    else if (!iorq_n && a[7:0] == 8'h80) rd_sel = 3'd4;
    else if (!iorq_n && a[6:0] == 7'h7a) rd_sel = 3'd5;
    else if (!iorq_n && a[6:0] == 7'h7b) rd_sel = 3'd6;
  end
  assign vid_wr = !mreq_n && !wr_n && ctl80_q[5];
  always_comb begin
    vram_we_n = '1;
    for (int k = 0; k < PLANES; k++)
      vram_we_n[k] = !(vid_wr && bank7f_q[k+1] && grant);
  end
  always_comb begin
    blank_mask    = '0;
    blank_mask[0] = tog_q && ctl80_q[2];
    blank_mask[1] = tog_q && ctl80_q[3];
  end
  assign bank7f   = bank7f_q;
  assign ctl80    = ctl80_q;
  assign altg     = ctl80_q[4];
  assign ram_we_n = !(!mreq_n && !wr_n && !bank7f_q[0]);
  assign vram_a   = {a[14], a[12:0]};
  assign rom_a    = a[ROM_AW-1:0];
`ifdef LYNX_BANK_WAIT_EN
  typedef enum logic [1:0] {IDLE, HOLD, COUNT, GRANT} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wait_q, vid_cyc;
  always_comb begin
    vid_cyc = !mreq_n && ((vid_wr && |bank7f_q[PLANES:1]) || rd_sel == 3'd3);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (vid_cyc) begin
               state_d = de ? HOLD : COUNT;
               cnt_d   = 4'(VWAIT - 1);
             end
      HOLD:  if (!de) begin
               state_d = COUNT;
               cnt_d   = 4'(VWAIT - 1);
             end
      COUNT: if (cnt_q == 4'd0) state_d = GRANT;
             else cnt_d = cnt_q - 4'd1;
      GRANT: if (mreq_n) state_d = IDLE;
    endcase
  end
  // wait_n is registered from the next state so it is glitch-free and clears asynchronously on reset.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wait_q  <= 1'b1;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= !(state_d == HOLD || state_d == COUNT);
    end
  assign grant  = state_q == GRANT;
  assign wait_n = wait_q;
`else
  logic unused_de;
  assign unused_de = de;
  assign grant     = 1'b1;
  assign wait_n    = 1'b1;
`endif
endmodule
